// File: rtl/halfband_interp2.sv
`default_nettype none
// ============================================================================
// Module   : halfband_interp2
// Desc     : Pipelined polyphase halfband interpolate-by-2 filter with
//            run-time coefficients, output saturation and overrun flag.
//            Optional macro HBI_ROUND_EN: round half up on the convolution
//            phase instead of floor. NZ must be at least 2.
// Revision : 1.0  initial release
// ============================================================================
module halfband_interp2 #(
  parameter int                  WIDTH     = 18,
  parameter int                  NZ        = 4,
  parameter logic [NZ*WIDTH-1:0] COEF_INIT = {18'sd78535, -18'sd15925, 18'sd3274, -18'sd348}
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     in_en,
  input  logic signed [WIDTH-1:0]  x_in,
  input  logic                     coef_we,
  input  logic [$clog2(NZ)-1:0]    coef_addr,
  input  logic signed [WIDTH-1:0]  coef_din,
  output logic signed [WIDTH-1:0]  y,
  output logic                     out_en,
  output logic                     out_phase,
  output logic                     sat,
  output logic                     ovf_err
);

  localparam int c_AW   = $clog2(NZ);
  localparam int c_LVL  = $clog2(NZ);
  localparam int c_NP   = 1 << c_LVL;
  localparam int c_LAT  = 3 + c_LVL;
  localparam int c_ACCW = 2*WIDTH + 1 + c_LVL;
`ifdef HBI_ROUND_EN
  localparam logic signed [c_ACCW:0] c_RND = {{(c_ACCW-WIDTH+2){1'b0}}, 1'b1, {(WIDTH-2){1'b0}}};
`else
  localparam logic signed [c_ACCW:0] c_RND = '0;
`endif

  logic signed [WIDTH-1:0]  r_coef [NZ];
  logic signed [WIDTH-1:0]  r_d    [2*NZ];
  logic signed [WIDTH:0]    r_pair [NZ];
  // Heap-ordered adder tree; node 0 (the root) is folded into the output stage.
  logic signed [c_ACCW-1:0] r_tree [1:2*c_NP-2];
  logic                     r_vld  [1:c_LAT-1];
  logic signed [WIDTH-1:0]  r_ctr  [2:c_LAT-1];
  logic signed [WIDTH-1:0]  r_bval;
  logic                     r_bpend;
  logic                     r_prev_en;
  logic                     r_ovf;
  logic signed [WIDTH-1:0]  r_y;
  logic                     r_out_en;
  logic                     r_phase;
  logic                     r_sat;

  logic signed [c_ACCW:0]   w_acc;
  logic                     w_clip;
  logic signed [WIDTH-1:0]  w_ya;
  logic                     w_unused_lsb;

  always_comb begin
    w_acc  = (c_ACCW+1)'(r_tree[1]) + (c_ACCW+1)'(r_tree[2]) + c_RND;
    w_clip = !((&w_acc[c_ACCW:2*WIDTH-2]) || !(|w_acc[c_ACCW:2*WIDTH-2]));
    if (!w_clip)
      w_ya = w_acc[2*WIDTH-2:WIDTH-1];
    else if (w_acc[c_ACCW])
      w_ya = {1'b1, {(WIDTH-1){1'b0}}};
    else
      w_ya = {1'b0, {(WIDTH-1){1'b1}}};
  end

  // Fractional bits below the output LSB are dropped by the shift.
  assign w_unused_lsb = ^w_acc[WIDTH-2:0];

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int k = 0; k < NZ; k++)          r_coef[k] <= COEF_INIT[k*WIDTH +: WIDTH];
      for (int k = 0; k < 2*NZ; k++)        r_d[k]    <= '0;
      for (int k = 0; k < NZ; k++)          r_pair[k] <= '0;
      for (int n = 1; n <= 2*c_NP-2; n++)   r_tree[n] <= '0;
      for (int k = 1; k < c_LAT; k++)       r_vld[k]  <= 1'b0;
      for (int k = 2; k < c_LAT; k++)       r_ctr[k]  <= '0;
      r_bval    <= '0;
      r_bpend   <= 1'b0;
      r_prev_en <= 1'b0;
      r_ovf     <= 1'b0;
      r_y       <= '0;
      r_out_en  <= 1'b0;
      r_phase   <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      // Out-of-range addresses match no index and are dropped.
      for (int k = 0; k < NZ; k++)
        if (coef_we && coef_addr == c_AW'(k)) r_coef[k] <= coef_din;

      if (in_en) begin
        r_d[0] <= x_in;
        for (int k = 1; k < 2*NZ; k++) r_d[k] <= r_d[k-1];
      end

      for (int k = 0; k < NZ; k++)
        r_pair[k] <= (WIDTH+1)'(r_d[k]) + (WIDTH+1)'(r_d[2*NZ-1-k]);
      for (int i = 0; i < NZ; i++)
        r_tree[c_NP-1+i] <= c_ACCW'(r_pair[i]) * c_ACCW'(r_coef[i]);
      for (int i = NZ; i < c_NP; i++)
        r_tree[c_NP-1+i] <= '0;
      for (int n = 1; n <= c_NP-2; n++)
        r_tree[n] <= r_tree[2*n+1] + r_tree[2*n+2];

      r_vld[1] <= in_en;
      for (int k = 2; k < c_LAT; k++) r_vld[k] <= r_vld[k-1];
      r_ctr[2] <= r_d[NZ-1];
      for (int k = 3; k < c_LAT; k++) r_ctr[k] <= r_ctr[k-1];

      r_prev_en <= in_en;
      if (in_en && r_prev_en) r_ovf <= 1'b1;

      // A fresh convolution result always wins the slot; a pending centre
      // output is overwritten when samples arrive back to back.
      if (r_vld[c_LAT-1]) begin
        r_y      <= w_ya;
        r_out_en <= 1'b1;
        r_phase  <= 1'b0;
        r_sat    <= w_clip;
        r_bval   <= r_ctr[c_LAT-1];
        r_bpend  <= 1'b1;
      end else if (r_bpend) begin
        r_y      <= r_bval;
        r_out_en <= 1'b1;
        r_phase  <= 1'b1;
        r_sat    <= 1'b0;
        r_bpend  <= 1'b0;
      end else begin
        r_out_en <= 1'b0;
        r_sat    <= 1'b0;
      end
    end
  end

  assign y         = r_y;
  assign out_en    = r_out_en;
  assign out_phase = r_phase;
  assign sat       = r_sat;
  assign ovf_err   = r_ovf | (in_en & r_prev_en);

endmodule
`default_nettype wire

// File: tb/tb_halfband_interp2.sv
`default_nettype none
// ============================================================================
// Module   : tb_halfband_interp2
// Desc     : Directed self-checking bench for halfband_interp2.
// Revision : 1.0  initial release
// ============================================================================
module tb_halfband_interp2;
  localparam int W = 18;
`ifdef HBI_ROUND_EN
  localparam int C1H = -7962;
  localparam int C3H = 39268;
`else
  localparam int C1H = -7963;
  localparam int C3H = 39267;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                in_en;
  logic signed [W-1:0] x_in;
  logic                coef_we;
  logic [1:0]          coef_addr;
  logic signed [W-1:0] coef_din;
  logic signed [W-1:0] y;
  logic                out_en;
  logic                out_phase;
  logic                sat;
  logic                ovf_err;

  int cyc  = 0;
  int nerr = 0;
  int nchk = 0;

  typedef struct {
    int                  cyc;
    logic signed [W-1:0] y;
    logic                ph;
    logic                sat;
  } ev_t;
  ev_t evq[$];
  int  tin[$];

  int ea[12] = '{-174, 1637, C1H, C3H, C3H, C1H, 1637, -174, 0, 0, 0, 0};
  int eb[12] = '{0, 0, 0, 65536, 0, 0, 0, 0, 0, 0, 0, 0};

  halfband_interp2 dut (
    .sys_clk   (clk),
    .reset     (reset),
    .in_en     (in_en),
    .x_in      (x_in),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_din  (coef_din),
    .y         (y),
    .out_en    (out_en),
    .out_phase (out_phase),
    .sat       (sat),
    .ovf_err   (ovf_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (out_en === 1'b1) evq.push_back('{cyc, y, out_phase, sat});

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic signed [W-1:0] x, input int gap);
    in_en = 1'b1;
    x_in  = x;
    tin.push_back(cyc);
    tick(1);
    in_en = 1'b0;
    x_in  = '0;
    if (gap > 1) tick(gap - 1);
  endtask

  task automatic run_impulse(input string tag);
    evq.delete();
    tin.delete();
    send(18'sd65536, 4);
    repeat (11) send('0, 4);
    tick(10);
    chk({tag, "_count"}, evq.size(), 24);
    for (int i = 0; i < 12; i++) begin
      if (2*i+1 < evq.size()) begin
        chk($sformatf("%s_A%0d_y", tag, i),   evq[2*i].y,     ea[i]);
        chk($sformatf("%s_A%0d_ph", tag, i),  evq[2*i].ph,    0);
        chk($sformatf("%s_A%0d_cyc", tag, i), evq[2*i].cyc,   tin[i] + 5);
        chk($sformatf("%s_B%0d_y", tag, i),   evq[2*i+1].y,   eb[i]);
        chk($sformatf("%s_B%0d_ph", tag, i),  evq[2*i+1].ph,  1);
        chk($sformatf("%s_B%0d_cyc", tag, i), evq[2*i+1].cyc, tin[i] + 6);
      end
    end
  endtask

  task automatic run_dc(input string tag, input logic signed [W-1:0] x, input logic sat_a);
    evq.delete();
    tin.delete();
    repeat (12) send(x, 2);
    tick(10);
    chk({tag, "_count"}, evq.size(), 24);
    for (int i = 8; i < 12; i++) begin
      if (2*i+1 < evq.size()) begin
        chk($sformatf("%s_A%0d_y", tag, i),   evq[2*i].y,     x);
        chk($sformatf("%s_A%0d_sat", tag, i), evq[2*i].sat,   sat_a);
        chk($sformatf("%s_B%0d_y", tag, i),   evq[2*i+1].y,   x);
        chk($sformatf("%s_B%0d_sat", tag, i), evq[2*i+1].sat, 0);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    in_en     = 1'b0;
    x_in      = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_din  = '0;
    tick(3);
    chk("rst_y",         y,         0);
    chk("rst_out_en",    out_en,    0);
    chk("rst_out_phase", out_phase, 0);
    chk("rst_sat",       sat,       0);
    chk("rst_ovf_err",   ovf_err,   0);
    reset = 1'b0;
    tick(1);
    chk("rst_release_out_en", out_en, 0);

    run_impulse("imp");

    // Single sample: exactly two strobes at +5 and +6.
    evq.delete();
    tin.delete();
    send(18'sd65536, 1);
    tick(20);
    chk("lat_count", evq.size(), 2);
    if (evq.size() > 0) begin
      chk("lat_A_cyc", evq[0].cyc, tin[0] + 5);
      chk("lat_A_ph",  evq[0].ph,  0);
      chk("lat_A_y",   evq[0].y,   -174);
    end
    if (evq.size() > 1) begin
      chk("lat_B_cyc", evq[1].cyc, tin[0] + 6);
      chk("lat_B_ph",  evq[1].ph,  1);
      chk("lat_B_y",   evq[1].y,   0);
    end

    run_dc("dc", 18'sd131071, 1'b0);
    chk("dc_hold_y",      y,      131071);
    chk("dc_hold_out_en", out_en, 0);

    coef_we   = 1'b1;
    coef_addr = 2'd3;
    coef_din  = 18'sd131071;
    tick(1);
    coef_we   = 1'b0;
    run_dc("satp", 18'sd131071, 1'b1);
    run_dc("satn", -18'sd131072, 1'b1);

    // Overrun: back-to-back strobes after a clean reset.
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(2);
    chk("ovr_pre", ovf_err, 0);
    evq.delete();
    tin.delete();
    in_en = 1'b1;
    x_in  = 18'sd65536;
    tin.push_back(cyc);
    #1;
    chk("ovr_first_strobe", ovf_err, 0);
    tick(1);
    x_in = '0;
    tin.push_back(cyc);
    #1;
    chk("ovr_second_strobe", ovf_err, 1);
    tick(1);
    in_en = 1'b0;
    tick(3);
    chk("ovr_sticky", ovf_err, 1);
    tick(10);
    chk("ovr_sticky_late", ovf_err, 1);
    chk("ovr_count", evq.size(), 3);
    if (evq.size() == 3) begin
      chk("ovr_e0_cyc", evq[0].cyc, tin[0] + 5);
      chk("ovr_e0_ph",  evq[0].ph,  0);
      chk("ovr_e0_y",   evq[0].y,   -174);
      chk("ovr_e1_cyc", evq[1].cyc, tin[1] + 5);
      chk("ovr_e1_ph",  evq[1].ph,  0);
      chk("ovr_e1_y",   evq[1].y,   1637);
      chk("ovr_e2_cyc", evq[2].cyc, tin[1] + 6);
      chk("ovr_e2_ph",  evq[2].ph,  1);
      chk("ovr_e2_y",   evq[2].y,   0);
    end
    reset = 1'b1;
    tick(1);
    chk("ovr_reset_clears", ovf_err, 0);
    reset = 1'b0;
    tick(2);

    // Reset in the middle of a burst with a modified coefficient.
    coef_we   = 1'b1;
    coef_addr = 2'd2;
    coef_din  = '0;
    tick(1);
    coef_we   = 1'b0;
    tick(2);
    evq.delete();
    tin.delete();
    send(18'sd65536, 4);
    send('0, 4);
    send('0, 1);
    chk("mid_pre_y", y, 1637);
    reset = 1'b1;
    tick(1);
    chk("mid_y",         y,         0);
    chk("mid_out_en",    out_en,    0);
    chk("mid_out_phase", out_phase, 0);
    chk("mid_sat",       sat,       0);
    evq.delete();
    tick(1);
    reset = 1'b0;
    tick(15);
    chk("mid_no_strobe", evq.size(), 0);

    run_impulse("imp2");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
